// File: rtl/cp0_regs.sv
// -----------------------------------------------------------------------------
// cp0_regs : Coprocessor-0 register file and interrupt unit for the
//            multi-cycle MIPS core.
//
// Holds Count, Compare, Status, Cause and EPC. It also runs the Count/Compare
// timer, synchronises the external interrupt pins, and produces a registered
// interrupt request for the control FSM.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   WriteCp0    mtc0 write strobe (target selected by rd_addr)
//   WriteEPC    capture epc_in (word aligned) into EPC
//   WriteCause  exception entry: load ExcCode, set Status.EXL
//   InTcause    exception kind for WriteCause: 1 = syscall, 0 = interrupt
//   eret        exception return: clear Status.EXL
//   rd_addr     CP0 register number (Inst[15:11]), used for reads and writes
//   wdata       mtc0 write data
//   epc_in      exception PC from the ALU result
//   ext_int     asynchronous external interrupt pins (drive Cause.IP6:2)
//   rdata       mfc0 read data, combinational on rd_addr
//   epc_out     current EPC, to the PC source mux
//   int_req     registered interrupt request to the control FSM
// -----------------------------------------------------------------------------
module cp0_regs #(
  parameter int unsigned COUNT_DIV = 2,      // clock cycles per Count increment, >= 1
  parameter logic [4:0]  EXC_SYS   = 5'd8,   // ExcCode for a syscall
  parameter logic [4:0]  EXC_INT   = 5'd0    // ExcCode for an interrupt
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WriteCp0,
  input  logic        WriteEPC,
  input  logic        WriteCause,
  input  logic        InTcause,
  input  logic        eret,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] wdata,
  input  logic [31:0] epc_in,
  input  logic [4:0]  ext_int,
  output logic [31:0] rdata,
  output logic [31:0] epc_out,
  output logic        int_req
);

  typedef enum logic [4:0] {
    CP0_COUNT   = 5'd9,
    CP0_COMPARE = 5'd11,
    CP0_STATUS  = 5'd12,
    CP0_CAUSE   = 5'd13,
    CP0_EPC     = 5'd14
  } cp0_addr_e;

  // The prescaler needs at least one bit even when COUNT_DIV is 1.
  localparam int unsigned    PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(COUNT_DIV - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [4:0]    sync1_q, sync2_q;     // two-flop synchroniser for ext_int
  logic [PW-1:0] presc_q;
  logic [31:0]   count_q;
  logic [31:0]   compare_q;
  logic [31:0]   epc_q;
  logic [7:0]    im_q;                 // Status.IM
  logic          exl_q;                // Status.EXL
  logic          ie_q;                 // Status.IE
  logic          ip7_q;                // Cause.IP7, sticky timer interrupt
  logic [1:0]    ip_sw_q;              // Cause.IP1:0, software interrupts
  logic [4:0]    exc_code_q;           // Cause.ExcCode
  logic          int_req_q;

  // ---------------------------------------------------------------------------
  // Write decode and derived values
  // ---------------------------------------------------------------------------
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic        presc_wrap;
  logic        timer_match;
  logic [7:0]  ip;
  logic [31:0] status_word, cause_word;

  assign wr_count   = WriteCp0 && (rd_addr == CP0_COUNT);
  assign wr_compare = WriteCp0 && (rd_addr == CP0_COMPARE);
  assign wr_status  = WriteCp0 && (rd_addr == CP0_STATUS);
  assign wr_cause   = WriteCp0 && (rd_addr == CP0_CAUSE);
  assign wr_epc     = WriteCp0 && (rd_addr == CP0_EPC);

  assign presc_wrap  = (presc_q == PRESC_LAST);
  // Compare == 0 means the timer is disarmed.
  assign timer_match = (count_q == compare_q) && (compare_q != 32'd0);

  // IP6:2 come straight from the synchroniser output: level sensitive,
  // two cycles behind the pins.
  assign ip          = {ip7_q, sync2_q, ip_sw_q};
  assign status_word = {16'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_word  = {16'd0, ip, 1'b0, exc_code_q, 2'b00};

  // EPC is always word aligned, so the pin's low bits are never stored.
  logic unused_epc_lsbs;
  assign unused_epc_lsbs = ^epc_in[1:0];

  // ---------------------------------------------------------------------------
  // External interrupt synchroniser
  // ---------------------------------------------------------------------------
  // NOTE: every flop here uses <= so all registers update from pre-edge
  // values; blocking assignments would let later statements see new values.
  // NOTE: every register is reset (none of this is a RAM), so software
  // always sees a defined CP0 state after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ext_int;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Count and prescaler: an mtc0 to Count restarts the prescaler phase and
  // takes precedence over the increment in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      count_q <= '0;
    end else if (wr_count) begin
      presc_q <= '0;
      count_q <= wdata;
    end else if (presc_wrap) begin
      presc_q <= '0;
      count_q <= count_q + 32'd1;   // wraps 0xFFFFFFFF -> 0 naturally
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Compare and the sticky timer interrupt. Writing Compare acknowledges the
  // timer, and that acknowledge beats a match in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      compare_q <= '0;
      ip7_q     <= 1'b0;
    end else begin
      if (wr_compare) begin
        compare_q <= wdata;
      end
      if (wr_compare) begin
        ip7_q <= 1'b0;
      end else if (timer_match) begin
        ip7_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status. EXL priority, highest first: exception entry, eret, mtc0.
  // IM and IE still take an mtc0 value during exception entry.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= '0;
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
    end else begin
      if (wr_status) begin
        im_q <= wdata[15:8];
        ie_q <= wdata[0];
      end
      if (WriteCause) begin
        exl_q <= 1'b1;
      end else if (eret) begin
        exl_q <= 1'b0;
      end else if (wr_status) begin
        exl_q <= wdata[1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cause: only the software interrupt bits are writable by mtc0; ExcCode is
  // loaded on exception entry only.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ip_sw_q    <= '0;
      exc_code_q <= '0;
    end else begin
      if (wr_cause) begin
        ip_sw_q <= wdata[9:8];
      end
      if (WriteCause) begin
        exc_code_q <= InTcause ? EXC_SYS : EXC_INT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // EPC: hardware capture beats an mtc0 in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_q <= '0;
    end else if (WriteEPC) begin
      epc_q <= {epc_in[31:2], 2'b00};
    end else if (wr_epc) begin
      epc_q <= {wdata[31:2], 2'b00};
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt request, registered from the current CP0 state. Because EXL
  // feeds it, it drops one cycle after exception entry.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_req_q <= 1'b0;
    end else begin
      int_req_q <= ie_q & ~exl_q & (|(ip & im_q));
    end
  end

  // ---------------------------------------------------------------------------
  // mfc0 read mux
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational; any path leaving rdata unassigned would infer a latch.
  always_comb begin
    rdata = '0;
    case (rd_addr)
      CP0_COUNT:   rdata = count_q;
      CP0_COMPARE: rdata = compare_q;
      CP0_STATUS:  rdata = status_word;
      CP0_CAUSE:   rdata = cause_word;
      CP0_EPC:     rdata = epc_q;
      default:     rdata = '0;
    endcase
  end

  assign epc_out = epc_q;
  assign int_req = int_req_q;

endmodule

// File: tb/tb_cp0_regs.sv
// -----------------------------------------------------------------------------
// tb_cp0_regs : self-checking bench for cp0_regs.
// Directed vectors and multi-cycle corner sequences, then randomized traffic
// compared against a register-image reference model.
// -----------------------------------------------------------------------------
module tb_cp0_regs;

  localparam int unsigned CDIV = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        WriteCp0 = 1'b0, WriteEPC = 1'b0, WriteCause = 1'b0;
  logic        InTcause = 1'b0, eret = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] wdata = '0, epc_in = '0;
  logic [4:0]  ext_int = '0;
  logic [31:0] rdata, epc_out;
  logic        int_req;

  int n_cmp  = 0;
  int n_fail = 0;

  cp0_regs #(.COUNT_DIV(CDIV), .EXC_SYS(5'd8), .EXC_INT(5'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .WriteCp0   (WriteCp0),
    .WriteEPC   (WriteEPC),
    .WriteCause (WriteCause),
    .InTcause   (InTcause),
    .eret       (eret),
    .rd_addr    (rd_addr),
    .wdata      (wdata),
    .epc_in     (epc_in),
    .ext_int    (ext_int),
    .rdata      (rdata),
    .epc_out    (epc_out),
    .int_req    (int_req)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers. Inputs change 1 ns after a rising edge; outputs are sampled
  // there as well, well away from the next edge.
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    WriteCp0 = 1'b1;
    rd_addr  = addr;
    wdata    = data;
    step();
    WriteCp0 = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, output logic [31:0] val);
    rd_addr = addr;
    #1;
    val = rdata;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: full 32-bit register images with the architectural
  // write masks applied arithmetically.
  // ---------------------------------------------------------------------------
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic [4:0]  m_pins[2];      // [0] = pin value two edges ago (visible as IP6:2)
  int          m_phase;        // cycles since the last Count tick
  logic        m_int_req;

  function automatic void model_reset();
    m_count   = '0;
    m_compare = '0;
    m_status  = '0;
    m_cause   = '0;
    m_epc     = '0;
    m_pins[0] = '0;
    m_pins[1] = '0;
    m_phase   = 0;
    m_int_req = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    case (addr)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause | ({27'd0, m_pins[0]} << 10);
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_edge();
    logic [31:0] cause_now = model_read(5'd13);
    logic        pending   = ((cause_now[15:8] & m_status[15:8]) != 8'd0);
    logic        hit       = (m_count == m_compare) && (m_compare != 0);
    m_int_req = m_status[0] && !m_status[1] && pending;

    if (WriteEPC)                          m_epc = epc_in & 32'hFFFF_FFFC;
    else if (WriteCp0 && rd_addr == 5'd14) m_epc = wdata  & 32'hFFFF_FFFC;

    if (WriteCp0 && rd_addr == 5'd11) begin
      m_compare = wdata;
      m_cause   = m_cause & ~32'h0000_8000;
    end else if (hit) begin
      m_cause   = m_cause | 32'h0000_8000;
    end

    if (WriteCp0 && rd_addr == 5'd9) begin
      m_count = wdata;
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == int'(CDIV)) begin
        m_phase = 0;
        m_count = m_count + 1;
      end
    end

    if (WriteCp0 && rd_addr == 5'd12) m_status = wdata & 32'h0000_FF03;
    if (eret)       m_status = m_status & ~32'h2;
    if (WriteCause) m_status = m_status |  32'h2;

    if (WriteCp0 && rd_addr == 5'd13)
      m_cause = (m_cause & ~32'h0000_0300) | (wdata & 32'h0000_0300);
    if (WriteCause)
      m_cause = (m_cause & ~32'h0000_007C) | ((InTcause ? 32'd8 : 32'd0) << 2);

    m_pins[0] = m_pins[1];
    m_pins[1] = ext_int;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vectors: one mtc0, then a read on the following cycle.
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] v;
    logic [4:0]  reset_addrs[6];
    int          hit;

    vecs[0] = '{"status_mask",   5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0000_FF03};
    vecs[1] = '{"cause_mask",    5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
    vecs[2] = '{"epc_mtc0_align",5'd14, 32'h1234_5677, 5'd14, 32'h1234_5674};
    vecs[3] = '{"compare_rw",    5'd11, 32'hDEAD_BEEF, 5'd11, 32'hDEAD_BEEF};
    vecs[4] = '{"count_load",    5'd9,  32'h0000_0100, 5'd9,  32'h0000_0100};
    vecs[5] = '{"unimpl_reg",    5'd5,  32'hFFFF_FFFF, 5'd5,  32'h0000_0000};
    vecs[6] = '{"status_clear",  5'd12, 32'h0000_0000, 5'd12, 32'h0000_0000};
    vecs[7] = '{"cause_clear",   5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};

    reset_addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd5};

    // ---- Reset state, read while reset is held ----
    #1;
    foreach (reset_addrs[i]) begin
      rd(reset_addrs[i], v);
      check($sformatf("reset_rd_%0d", reset_addrs[i]), v, 32'd0);
    end
    check("reset_epc_out", epc_out, 32'd0);
    check("reset_int_req", {31'd0, int_req}, 32'd0);
    step();
    reset = 1'b1;

    // ---- Table-driven mtc0 / mfc0 ----
    for (int i = 0; i < 8; i++) begin
      mtc0(vecs[i].waddr, vecs[i].data);
      rd(vecs[i].raddr, v);
      check(vecs[i].name, v, vecs[i].exp);
    end
    check("epc_out_follows_mtc0", epc_out, 32'h1234_5674);

    // ---- Syscall entry and eret ----
    WriteEPC = 1'b1; epc_in = 32'h0000_0107; WriteCause = 1'b1; InTcause = 1'b1;
    step();
    WriteEPC = 1'b0; WriteCause = 1'b0; InTcause = 1'b0;
    check("sys_epc_out", epc_out, 32'h0000_0104);
    rd(5'd13, v);
    check("sys_exccode", (v >> 2) & 32'h1F, 32'd8);
    rd(5'd12, v);
    check("sys_exl_set", v & 32'h2, 32'h2);
    eret = 1'b1;
    step();
    eret = 1'b0;
    rd(5'd12, v);
    check("eret_exl_clear", v & 32'h2, 32'h0);

    // ---- Same-cycle conflicts on Status / EPC ----
    eret = 1'b1; WriteCause = 1'b1; InTcause = 1'b0;
    step();
    eret = 1'b0; WriteCause = 1'b0;
    rd(5'd12, v);
    check("eret_vs_cause_exl", v & 32'h2, 32'h2);
    rd(5'd13, v);
    check("int_exccode", (v >> 2) & 32'h1F, 32'd0);
    WriteCause = 1'b1;
    mtc0(5'd12, 32'h0000_AA00);
    WriteCause = 1'b0;
    rd(5'd12, v);
    check("mtc0_status_vs_cause", v, 32'h0000_AA02);
    WriteEPC = 1'b1; epc_in = 32'h2000_0001;
    mtc0(5'd14, 32'h5555_5555);
    WriteEPC = 1'b0;
    check("epc_hw_priority", epc_out, 32'h2000_0000);

    // ---- External interrupt path ----
    pulse_reset();
    mtc0(5'd12, 32'h0000_0401);
    ext_int = 5'b00001;            // pin rises during cycle t
    step();
    rd(5'd13, v);
    check("ip2_t1", v & 32'h400, 32'h0);
    step();
    rd(5'd13, v);
    check("ip2_t2", v & 32'h400, 32'h400);
    check("int_req_t2", {31'd0, int_req}, 32'd0);
    step();
    check("int_req_t3", {31'd0, int_req}, 32'd1);
    WriteCause = 1'b1; InTcause = 1'b0;
    step();
    WriteCause = 1'b0;
    check("int_req_exl_edge", {31'd0, int_req}, 32'd1);
    step();
    check("int_req_exl_drop", {31'd0, int_req}, 32'd0);
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    check("int_req_after_eret", {31'd0, int_req}, 32'd1);
    reset = 1'b0;                  // asynchronous, mid-cycle
    #1;
    check("int_req_async_reset", {31'd0, int_req}, 32'd0);
    rd(5'd12, v);
    check("status_async_reset", v, 32'd0);
    ext_int = '0;
    step();
    reset = 1'b1;

    // ---- Timer: Compare = 10, Count = 0 ----
    mtc0(5'd11, 32'd10);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9,  32'd0);
    rd_addr = 5'd13;
    hit = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (rdata[15]) begin
        hit = i;
        break;
      end
    end
    check("ip7_latency", hit, 32'd21);
    check("ip7_int_req_lag", {31'd0, int_req}, 32'd0);
    step();
    check("ip7_int_req", {31'd0, int_req}, 32'd1);
    mtc0(5'd11, 32'd50);
    rd(5'd13, v);
    check("ip7_clear", v & 32'h8000, 32'h0);
    check("int_req_hold", {31'd0, int_req}, 32'd1);
    step();
    check("int_req_drop", {31'd0, int_req}, 32'd0);

    // ---- Count write on the prescaler wrap, and Count wrap-around ----
    mtc0(5'd9, 32'd0);
    step();
    mtc0(5'd9, 32'd5);             // this edge is also a prescaler wrap
    rd(5'd9, v);
    check("count_write_wins", v, 32'd5);
    step();
    rd(5'd9, v);
    check("count_presc_cleared", v, 32'd5);
    step();
    rd(5'd9, v);
    check("count_incr", v, 32'd6);
    mtc0(5'd9, 32'hFFFF_FFFF);
    step();
    rd(5'd9, v);
    check("count_max", v, 32'hFFFF_FFFF);
    step();
    rd(5'd9, v);
    check("count_wrap", v, 32'd0);

    // ---- Randomized traffic against the model ----
    model_reset();
    ext_int = '0;
    pulse_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      WriteCp0 = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       rd_addr = 5'd9;
        1:       rd_addr = 5'd11;
        2:       rd_addr = 5'd12;
        3:       rd_addr = 5'd13;
        4:       rd_addr = 5'd14;
        default: rd_addr = 5'($urandom);
      endcase
      case (rd_addr)
        5'd9:    wdata = $urandom_range(0, 30);
        5'd11:   wdata = $urandom_range(0, 40);
        default: wdata = $urandom;
      endcase
      WriteEPC   = ($urandom_range(0, 15) == 0);
      epc_in     = $urandom;
      WriteCause = ($urandom_range(0, 19) == 0);
      InTcause   = 1'($urandom_range(0, 1));
      eret       = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) ext_int = 5'($urandom);
      #1;
      check("rnd_rdata", rdata, model_read(rd_addr));
      model_edge();
      step();
      check("rnd_epc_out", epc_out, m_epc);
      check("rnd_int_req", {31'd0, int_req}, {31'd0, m_int_req});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
